// File: rtl/bpug_pkg.sv
// Shared constants, instruction-field layout, state encoding and small helpers
// for the BPU-group sequencer.
package bpug_pkg;

    localparam int INSTR_W    = 13;
    localparam int OP_LSB     = 0;
    localparam int OP_W       = 5;
    localparam int DSEL_BIT   = 5;
    localparam int EN_WGT_BIT = 6;
    localparam int EN_IMG_BIT = 7;
    localparam int UP_BIT     = 8;
    localparam int ISEL_BIT   = 9;
    localparam int WSEL_LSB   = 10;
    localparam int WSEL_W     = 3;

    localparam logic [INSTR_W-1:0] INSTR_NOP = 13'd0;

    localparam int WGT_WORDS = 56;
    localparam int IMG_WORDS = 16;
    localparam int MAX_ROWS  = 9;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_LOAD_WGT = 3'd1,
        ST_LOAD_IMG = 3'd2,
        ST_COMPUTE  = 3'd3,
        ST_SHIFT_UP = 3'd4,
        ST_DRAIN    = 3'd5,
        ST_DONE     = 3'd6
    } state_t;

    function automatic logic [INSTR_W-1:0] make_instr(
        input logic [OP_W-1:0]   op,
        input logic              dsel,
        input logic              en_img,
        input logic              en_wgt,
        input logic              up,
        input logic              isel,
        input logic [WSEL_W-1:0] wsel
    );
        logic [INSTR_W-1:0] w;
        w                       = INSTR_NOP;
        w[OP_LSB +: OP_W]       = op;
        w[DSEL_BIT]             = dsel;
        w[EN_WGT_BIT]           = en_wgt;
        w[EN_IMG_BIT]           = en_img;
        w[UP_BIT]               = up;
        w[ISEL_BIT]             = isel;
        w[WSEL_LSB +: WSEL_W]   = wsel;
        return w;
    endfunction

    // Zero rows would never compute, so it is promoted to one pass.
    function automatic logic [3:0] clamp_rows(input logic [3:0] r);
        logic [3:0] c;
        if (r == 4'd0) begin
            c = 4'd1;
        end else if (r > 4'(MAX_ROWS)) begin
            c = 4'(MAX_ROWS);
        end else begin
            c = r;
        end
        return c;
    endfunction

    function automatic logic [2:0] wgt_group(input logic [5:0] n);
        return 3'(n / 6'd7);
    endfunction

endpackage

// File: rtl/bpug_fetch.sv
// Address counter and single-outstanding read handshake for the on-chip
// buffer, shared by the weight and image load phases.
module bpug_fetch
    import bpug_pkg::*;
#(
    parameter int ADDR_W = 10
) (
    input  logic              clk_bpug,
    input  logic              rst,
    input  logic              flush,
    input  logic              launch,
    input  logic [ADDR_W-1:0] base,
    input  logic [5:0]        len,
    input  logic              rd_valid,
    output logic              rd_req,
    output logic [ADDR_W-1:0] rd_addr,
    output logic [5:0]        idx,
    output logic              accept,
    output logic              last
);

    logic              req_r;
    logic [ADDR_W-1:0] addr_r;
    logic [5:0]        idx_r;

    // A flushed request must not accept a response arriving on the same cycle.
    assign accept  = req_r & rd_valid & ~flush & ~rst;
    assign last    = accept & (idx_r == (len - 6'd1));
    assign rd_req  = req_r;
    assign rd_addr = addr_r;
    assign idx     = idx_r;

    // Request/address counter; a launch on the final accept chains straight into the next phase
    always_ff @(posedge clk_bpug) begin
        if (rst || flush) begin
            req_r  <= 1'b0;
            addr_r <= {ADDR_W{1'b0}};
            idx_r  <= 6'd0;
        end else if (launch) begin
            req_r  <= 1'b1;
            addr_r <= base;
            idx_r  <= 6'd0;
        end else if (accept) begin
            if (last) begin
                req_r <= 1'b0;
            end else begin
                idx_r  <= idx_r + 6'd1;
                addr_r <= addr_r + ADDR_W'(1'b1);
            end
        end
    end

endmodule

// File: rtl/bpug_sequencer.sv
// Layer-level controller for one BPU group: loads weights and image columns,
// steps the compute window and tags results. Optional stall counter: BPUG_SEQ_PERF_EN.
module bpug_sequencer
    import bpug_pkg::*;
#(
    parameter int BPU_LAT = 2,
    parameter int ADDR_W  = 10
) (
    input  logic              clk_bpug,
    input  logic              rst,
    input  logic              start,
    input  logic              abort,
    input  logic [4:0]        cfg_op,
    input  logic [2:0]        cfg_height,
    input  logic [3:0]        cfg_rows,
    input  logic [ADDR_W-1:0] cfg_wgt_base,
    input  logic [ADDR_W-1:0] cfg_img_base,
    output logic              rd_req,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic              rd_valid,
    input  logic [7:0]        rd_data,
    output logic [12:0]       instr,
    output logic [7:0]        data,
    output logic              sel,
    output logic [2:0]        height,
    output logic              out_valid,
    output logic [3:0]        out_row,
    output logic              out_col,
    output logic              busy,
    output logic              done
`ifdef BPUG_SEQ_PERF_EN
    ,
    output logic [15:0]       stall_cnt
`endif
);

    state_t       state_r;
    logic [3:0]   rows_r;
    logic [3:0]   row_r;
    logic         phase_r;
    logic [12:0]  instr_r;
    logic [7:0]   data_r;
    logic         sel_r;
    logic [2:0]   height_r;
    logic         busy_r;
    logic         done_r;
    logic         iss_v_r;
    logic [3:0]   iss_row_r;
    logic         iss_col_r;

    logic [BPU_LAT-1:0] v_pipe_r;
    logic [BPU_LAT-1:0] col_pipe_r;
    logic [3:0]         row_pipe_r [BPU_LAT];

    logic              fetch_launch_s;
    logic [ADDR_W-1:0] fetch_base_s;
    logic [5:0]        fetch_len_s;
    logic [5:0]        fetch_idx_s;
    logic              fetch_accept_s;
    logic              fetch_last_s;
    logic [BPU_LAT:0]  pend_s;
    logic              drain_clear_s;

    assign fetch_launch_s = ((state_r == ST_IDLE) && start) ||
                            ((state_r == ST_LOAD_WGT) && fetch_last_s);
    assign fetch_base_s   = (state_r == ST_IDLE) ? cfg_wgt_base : cfg_img_base;
    assign fetch_len_s    = (state_r == ST_LOAD_IMG) ? 6'(IMG_WORDS) : 6'(WGT_WORDS);

    bpug_fetch #(.ADDR_W(ADDR_W)) u_fetch (
        .clk_bpug (clk_bpug),
        .rst      (rst),
        .flush    (abort),
        .launch   (fetch_launch_s),
        .base     (fetch_base_s),
        .len      (fetch_len_s),
        .rd_valid (rd_valid),
        .rd_req   (rd_req),
        .rd_addr  (rd_addr),
        .idx      (fetch_idx_s),
        .accept   (fetch_accept_s),
        .last     (fetch_last_s)
    );

    // The last stage drops out by itself, so drain ends once every earlier stage is empty.
    assign pend_s        = {v_pipe_r, iss_v_r};
    assign drain_clear_s = ~|pend_s[BPU_LAT-1:0];

    // Sequencer state machine and registered BPUG-facing outputs
    always_ff @(posedge clk_bpug) begin
        if (rst || abort) begin
            state_r   <= ST_IDLE;
            rows_r    <= 4'd1;
            row_r     <= 4'd0;
            phase_r   <= 1'b0;
            instr_r   <= INSTR_NOP;
            data_r    <= 8'd0;
            sel_r     <= 1'b0;
            height_r  <= 3'd0;
            busy_r    <= 1'b0;
            done_r    <= 1'b0;
            iss_v_r   <= 1'b0;
            iss_row_r <= 4'd0;
            iss_col_r <= 1'b0;
        end else begin
            instr_r   <= INSTR_NOP;
            data_r    <= 8'd0;
            sel_r     <= 1'b0;
            done_r    <= 1'b0;
            iss_v_r   <= 1'b0;
            iss_row_r <= 4'd0;
            iss_col_r <= 1'b0;
            height_r  <= cfg_height;
            busy_r    <= 1'b1;
            case (state_r)
                ST_IDLE: begin
                    height_r <= 3'd0;
                    busy_r   <= 1'b0;
                    if (start) begin
                        state_r  <= ST_LOAD_WGT;
                        rows_r   <= clamp_rows(cfg_rows);
                        row_r    <= 4'd0;
                        phase_r  <= 1'b0;
                        height_r <= cfg_height;
                        busy_r   <= 1'b1;
                    end
                end
                ST_LOAD_WGT: begin
                    if (fetch_accept_s) begin
                        instr_r <= make_instr(5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0,
                                              wgt_group(fetch_idx_s));
                        data_r  <= rd_data;
                        if (fetch_last_s) begin
                            state_r <= ST_LOAD_IMG;
                        end
                    end
                end
                ST_LOAD_IMG: begin
                    if (fetch_accept_s) begin
                        instr_r <= make_instr(5'd0, 1'b0, 1'b1, 1'b0, 1'b0,
                                              fetch_idx_s[3], 3'd0);
                        data_r  <= rd_data;
                        sel_r   <= 1'b1;
                        if (fetch_last_s) begin
                            state_r <= ST_COMPUTE;
                            row_r   <= 4'd0;
                            phase_r <= 1'b0;
                        end
                    end
                end
                ST_COMPUTE: begin
                    instr_r   <= make_instr(cfg_op, phase_r, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0);
                    iss_v_r   <= 1'b1;
                    iss_row_r <= row_r;
                    iss_col_r <= phase_r;
                    phase_r   <= ~phase_r;
                    if (phase_r) begin
                        if (row_r < (rows_r - 4'd1)) begin
                            state_r <= ST_SHIFT_UP;
                        end else begin
                            state_r <= ST_DRAIN;
                        end
                    end
                end
                ST_SHIFT_UP: begin
                    instr_r <= make_instr(5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 3'd0);
                    row_r   <= row_r + 4'd1;
                    state_r <= ST_COMPUTE;
                end
                ST_DRAIN: begin
                    if (drain_clear_s) begin
                        state_r <= ST_DONE;
                        done_r  <= 1'b1;
                    end
                end
                ST_DONE: begin
                    state_r  <= ST_IDLE;
                    height_r <= 3'd0;
                    busy_r   <= 1'b0;
                end
                default: begin
                    state_r  <= ST_IDLE;
                    height_r <= 3'd0;
                    busy_r   <= 1'b0;
                end
            endcase
        end
    end

    // Result-tag delay line matching the BPU latency
    always_ff @(posedge clk_bpug) begin
        if (rst || abort) begin
            v_pipe_r   <= {BPU_LAT{1'b0}};
            col_pipe_r <= {BPU_LAT{1'b0}};
            for (int i = 0; i < BPU_LAT; i++) begin
                row_pipe_r[i] <= 4'd0;
            end
        end else begin
            v_pipe_r[0]   <= iss_v_r;
            col_pipe_r[0] <= iss_col_r;
            row_pipe_r[0] <= iss_row_r;
            for (int i = 1; i < BPU_LAT; i++) begin
                v_pipe_r[i]   <= v_pipe_r[i-1];
                col_pipe_r[i] <= col_pipe_r[i-1];
                row_pipe_r[i] <= row_pipe_r[i-1];
            end
        end
    end

    assign instr     = instr_r;
    assign data      = data_r;
    assign sel       = sel_r;
    assign height    = height_r;
    assign busy      = busy_r;
    assign done      = done_r;
    assign out_valid = v_pipe_r[BPU_LAT-1];
    assign out_col   = col_pipe_r[BPU_LAT-1];
    assign out_row   = row_pipe_r[BPU_LAT-1];

`ifdef BPUG_SEQ_PERF_EN
    logic [15:0] stall_cnt_r;

    // Saturating count of cycles spent waiting on the buffer
    always_ff @(posedge clk_bpug) begin
        if (rst) begin
            stall_cnt_r <= 16'd0;
        end else if ((state_r == ST_IDLE) && start && !abort) begin
            stall_cnt_r <= 16'd0;
        end else if (rd_req && !rd_valid && (stall_cnt_r != 16'hFFFF)) begin
            stall_cnt_r <= stall_cnt_r + 16'd1;
        end
    end

    assign stall_cnt = stall_cnt_r;
`endif

endmodule

// File: tb/tb_bpug_sequencer.sv
// Directed self-checking bench for bpug_sequencer with a behavioural buffer
// responder of programmable read latency.
module tb_bpug_sequencer;

    localparam int BPU_LAT = 2;
    localparam int ADDR_W  = 10;

    logic              clk_bpug = 1'b0;
    logic              rst;
    logic              start;
    logic              abort;
    logic [4:0]        cfg_op;
    logic [2:0]        cfg_height;
    logic [3:0]        cfg_rows;
    logic [ADDR_W-1:0] cfg_wgt_base;
    logic [ADDR_W-1:0] cfg_img_base;
    logic              rd_req;
    logic [ADDR_W-1:0] rd_addr;
    logic              rd_valid;
    logic [7:0]        rd_data;
    logic [12:0]       instr;
    logic [7:0]        data;
    logic              sel;
    logic [2:0]        height;
    logic              out_valid;
    logic [3:0]        out_row;
    logic              out_col;
    logic              busy;
    logic              done;
`ifdef BPUG_SEQ_PERF_EN
    logic [15:0]       stall_cnt;
`endif

    int checks   = 0;
    int failures = 0;
    int rsp_delay = 0;
    int rsp_cnt   = 0;
    bit force_valid = 1'b0;

    always #5 clk_bpug = ~clk_bpug;

    bpug_sequencer #(.BPU_LAT(BPU_LAT), .ADDR_W(ADDR_W)) dut (
        .clk_bpug     (clk_bpug),
        .rst          (rst),
        .start        (start),
        .abort        (abort),
        .cfg_op       (cfg_op),
        .cfg_height   (cfg_height),
        .cfg_rows     (cfg_rows),
        .cfg_wgt_base (cfg_wgt_base),
        .cfg_img_base (cfg_img_base),
        .rd_req       (rd_req),
        .rd_addr      (rd_addr),
        .rd_valid     (rd_valid),
        .rd_data      (rd_data),
        .instr        (instr),
        .data         (data),
        .sel          (sel),
        .height       (height),
        .out_valid    (out_valid),
        .out_row      (out_row),
        .out_col      (out_col),
        .busy         (busy),
        .done         (done)
`ifdef BPUG_SEQ_PERF_EN
        ,
        .stall_cnt    (stall_cnt)
`endif
    );

    function automatic logic [7:0] data_of(input logic [ADDR_W-1:0] a);
        return a[7:0] ^ 8'hA5;
    endfunction

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // One clock: buffer responder acts on the falling edge, outputs sampled 1ns after the rising edge.
    task automatic cyc();
        @(negedge clk_bpug);
        if (force_valid) begin
            rd_valid = 1'b1;
            rd_data  = 8'hEE;
        end else if (rd_req) begin
            if (rsp_cnt >= rsp_delay) begin
                rd_valid = 1'b1;
                rd_data  = data_of(rd_addr);
                rsp_cnt  = 0;
            end else begin
                rd_valid = 1'b0;
                rsp_cnt++;
            end
        end else begin
            rd_valid = 1'b0;
            rsp_cnt  = 0;
        end
        @(posedge clk_bpug);
        #1;
    endtask

    task automatic run_pass(input string name, input logic [3:0] rows_in, input int exp_rows,
                            input int delay, input int exp_len, input int busy_start_at);
        int n_w = 0;
        int n_i = 0;
        int n_c = 0;
        int n_u = 0;
        int n_v = 0;
        int cyc_n;
        bit seen_done = 1'b0;
        logic [ADDR_W-1:0] a;
        cfg_rows  = rows_in;
        rsp_delay = delay;
        rsp_cnt   = 0;
        start = 1'b1;
        cyc();
        start = 1'b0;
        cyc_n = 1;
        while (!seen_done && cyc_n < 2000) begin
            if (instr[6]) begin
                a = cfg_wgt_base + 10'(n_w);
                check_eq({name, "_wdata"}, 32'(data), 32'(data_of(a)));
                check_eq({name, "_wsel"}, 32'(instr[12:10]), n_w / 7);
                n_w++;
            end
            if (instr[7]) begin
                a = cfg_img_base + 10'(n_i);
                check_eq({name, "_idata"}, 32'(data), 32'(data_of(a)));
                check_eq({name, "_isel"}, 32'(instr[9]), (n_i >= 8) ? 1 : 0);
                check_eq({name, "_sel"}, 32'(sel), 1);
                n_i++;
            end
            if (instr[4:0] != 5'd0) begin
                check_eq({name, "_op"}, 32'(instr[4:0]), 32'(cfg_op));
                check_eq({name, "_dsel"}, 32'(instr[5]), n_c % 2);
                check_eq({name, "_cmp_en"}, 32'(instr[7:6]), 0);
                n_c++;
            end
            if (instr[8]) begin
                check_eq({name, "_up_en"}, 32'(instr[7:6]), 0);
                n_u++;
            end
            if (out_valid) begin
                check_eq({name, "_orow"}, 32'(out_row), n_v / 2);
                check_eq({name, "_ocol"}, 32'(out_col), n_v % 2);
                n_v++;
            end
            if (done) begin
                seen_done = 1'b1;
                check_eq({name, "_len"}, cyc_n, exp_len);
                check_eq({name, "_height"}, 32'(height), 32'(cfg_height));
            end else begin
                if (cyc_n == busy_start_at) start = 1'b1;
                cyc();
                start = 1'b0;
                cyc_n++;
            end
        end
        check_eq({name, "_done_seen"}, 32'(seen_done), 1);
        check_eq({name, "_n_wgt"}, n_w, 56);
        check_eq({name, "_n_img"}, n_i, 16);
        check_eq({name, "_n_cmp"}, n_c, 2 * exp_rows);
        check_eq({name, "_n_up"}, n_u, exp_rows - 1);
        check_eq({name, "_n_valid"}, n_v, 2 * exp_rows);
        cyc();
        check_eq({name, "_done_pulse"}, 32'(done), 0);
        check_eq({name, "_idle_busy"}, 32'(busy), 0);
        check_eq({name, "_idle_instr"}, 32'(instr), 0);
        check_eq({name, "_idle_height"}, 32'(height), 0);
    endtask

    initial begin
        int waited;
        rst = 1'b1; start = 1'b0; abort = 1'b0;
        rd_valid = 1'b0; rd_data = 8'd0;
        cfg_op = 5'h13; cfg_height = 3'd5; cfg_rows = 4'd1;
        cfg_wgt_base = 10'h120; cfg_img_base = 10'h2F8;
        repeat (3) cyc();
        rst = 1'b0;
        cyc();
        check_eq("rst_busy", 32'(busy), 0);
        check_eq("rst_done", 32'(done), 0);
        check_eq("rst_instr", 32'(instr), 0);
        check_eq("rst_req", 32'(rd_req), 0);
        check_eq("rst_ovalid", 32'(out_valid), 0);
        check_eq("rst_height", 32'(height), 0);

        run_pass("r1", 4'd1, 1, 0, 78, -1);
        cfg_op = 5'h07; cfg_height = 3'd3;
        run_pass("r9", 4'd9, 9, 0, 102, 85);
        run_pass("r0", 4'd0, 1, 0, 78, -1);
        cfg_op = 5'h1F; cfg_height = 3'd6;
        run_pass("r15", 4'd15, 9, 0, 102, 40);
        run_pass("slow", 4'd1, 1, 3, 294, -1);
`ifdef BPUG_SEQ_PERF_EN
        check_eq("stall_cnt", 32'(stall_cnt), 216);
`endif

        // Abort while weight word 20 is being requested and answered.
        rsp_delay = 0;
        cfg_rows = 4'd1;
        start = 1'b1;
        cyc();
        start = 1'b0;
        waited = 0;
        while (rd_addr != (cfg_wgt_base + 10'd20) && waited < 200) begin
            cyc();
            waited++;
        end
        check_eq("abort_reach", 32'(rd_addr), 32'(cfg_wgt_base + 10'd20));
        abort = 1'b1;
        cyc();
        abort = 1'b0;
        check_eq("abort_busy", 32'(busy), 0);
        check_eq("abort_req", 32'(rd_req), 0);
        check_eq("abort_instr", 32'(instr), 0);
        check_eq("abort_ovalid", 32'(out_valid), 0);
        force_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            cyc();
            check_eq("late_instr", 32'(instr), 0);
            check_eq("late_busy", 32'(busy), 0);
            check_eq("late_ovalid", 32'(out_valid), 0);
        end
        force_valid = 1'b0;
        cyc();

        // Reset while the compute pair is in flight.
        start = 1'b1;
        cyc();
        start = 1'b0;
        waited = 0;
        while (instr[4:0] == 5'd0 && waited < 200) begin
            cyc();
            waited++;
        end
        check_eq("rst_mid_reach", 32'(instr[4:0]), 32'(cfg_op));
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        check_eq("rst_mid_instr", 32'(instr), 0);
        check_eq("rst_mid_ovalid", 32'(out_valid), 0);
        check_eq("rst_mid_busy", 32'(busy), 0);
        check_eq("rst_mid_req", 32'(rd_req), 0);
        check_eq("rst_mid_data", 32'(data), 0);
        cyc();
        check_eq("rst_mid_ovalid2", 32'(out_valid), 0);
        run_pass("post_rst", 4'd1, 1, 0, 78, -1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/bpug_sequencer.md
# bpug_sequencer

Layer-level controller for one BPU group. It fetches weights and image columns from the on-chip buffer over a request/valid handshake and emits the 13-bit BPUG instruction word plus the 8-bit data word that go with it. It then steps the 7×7 compute window down the 16-row image register, and tags each BPU result column with a valid strobe. It sits between the layer scheduler (start/done) and the BPUG datapath.

## Interface
- BPU_LAT, 2, cycles from issuing a compute instruction to `bpu_out` being stable.
- ADDR_W, 10, buffer address width.
- clk_bpug  in  1  clock.
- rst  in  1  reset, synchronous, active-high.
- start  in  1  begin a layer pass; honoured only in IDLE.
- abort  in  1  return to IDLE next cycle from any state.
- cfg_op  in  5  BPU opcode issued during compute.
- cfg_height  in  3  passed through registered to BPUG `height`.
- cfg_rows  in  4  window positions; 0 is treated as 1, values above 9 are clamped to 9.
- cfg_wgt_base, cfg_img_base  in  ADDR_W  buffer base addresses.
- rd_req  out  1  buffer read request.
- rd_addr  out  ADDR_W  read address.
- rd_valid  in  1  `rd_data` valid; may arrive any number of cycles after `rd_req`.
- rd_data  in  8  buffer read data.
- instr  out  13  BPUG instruction word.
- data  out  8  BPUG `data_in`.
- sel  out  1  image-load select to BPUG.
- height  out  3  to BPUG.
- out_valid  out  1  `bpu_out` holds a result this cycle.
- out_row  out  4  window row of the current result.
- out_col  out  1  window column of the current result (0 = bits [6:0], 1 = bits [7:1]).
- busy, done  out  1  busy level and one-cycle completion pulse.

## Operation
- Instruction fields: [4:0] opcode; [5] data_sel; [7:6] en (bit 7 = image, bit 6 = weight); [8] img_reg_up; [9] img_reg_sel; [12:10] wgt_sel. NOP is all zero.
- States: IDLE, LOAD_WGT, LOAD_IMG, COMPUTE, SHIFT_UP, DRAIN, DONE.
- IDLE → LOAD_WGT on `start`. All outputs are zero in IDLE.
- LOAD_WGT loads 56 words, index n = 0..55:
  - `rd_addr` = cfg_wgt_base + n.
  - On `rd_valid`, the next cycle drives en = 01, wgt_sel = n/7, `data` = `rd_data`.
  - After n = 55 the state moves to LOAD_IMG.
- LOAD_IMG loads 16 words, index m = 0..15:
  - `rd_addr` = cfg_img_base + m.
  - On `rd_valid`, the next cycle drives en = 10, `sel` = 1, img_reg_sel = m[3], `data` = `rd_data`.
  - Then the state moves to COMPUTE with row = 0.
- A single `rd_req` stays outstanding and is held until `rd_valid`. Cycles without `rd_valid` issue NOP.
- COMPUTE takes 2 cycles:
  - Cycle 1 issues opcode = `cfg_op`, data_sel = 0.
  - Cycle 2 issues opcode = `cfg_op`, data_sel = 1.
  - If row < rows-1, go to SHIFT_UP; otherwise go to DRAIN.
- SHIFT_UP takes 1 cycle: img_reg_up = 1, en = 00. Then row increments and the state returns to COMPUTE.
- DRAIN waits until the BPU_LAT-deep valid pipeline is empty, then goes to DONE.
- DONE pulses `done` for one cycle, then returns to IDLE.
- `out_valid`, `out_row` and `out_col` are a BPU_LAT-stage delay of the compute issue and its tags. `abort` flushes this pipeline.
- `busy` = state ≠ IDLE.
- `abort` during a load: any late `rd_valid` is ignored, and `rd_req` drops the next cycle.
- Reset mid-operation: all outputs go to 0 and the state goes to IDLE the next edge.
- `start` while busy is ignored.

## Timing
- `instr`, `data`, `sel` and `height` are registered and change one cycle after the triggering event.
- Zero-stall pass length: 56 + 16 + rows·2 + (rows−1) + BPU_LAT + 2 cycles. `done` is high on the final cycle.
- `rd_valid` on the same cycle as `abort`: abort wins.

## Configuration
- BPUG_SEQ_PERF_EN defined:
  - Adds output `stall_cnt` (16 bits).
  - It counts cycles with `rd_req` high and `rd_valid` low, saturating at 0xFFFF.
  - It clears on `start`.
- Without the macro: no port and no counter logic.

## Structure
- Package `bpug_pkg`:
  - instruction-field bit positions;
  - NOP constant;
  - state enum;
  - WGT_WORDS = 56, IMG_WORDS = 16, MAX_ROWS = 9.
- Sub-module `bpug_fetch`: the address counter and the single-outstanding read handshake, shared by both load states.

## Test plan
- `start`, rows = 1, `rd_valid` same cycle as `rd_req`:
  - 56 weight words with wgt_sel stepping 0→7 every 7 words;
  - then 16 image words with img_reg_sel 0 for m < 8 and 1 for m ≥ 8;
  - then 2 compute instructions;
  - `out_valid` at col 0 and col 1;
  - `done` exactly 56+16+2+0+2+2 = 78 cycles after `start`.
- rows = 9: nine COMPUTE pairs and eight img_reg_up pulses with en = 00; `out_row` steps 0..8.
- `rd_valid` delayed 3 cycles per word: only NOPs during the gaps, no data lost; with BPUG_SEQ_PERF_EN, `stall_cnt` = 216.
- `abort` at weight word 20: IDLE next cycle, `busy` = 0, no `out_valid`; a late `rd_valid` produces no instruction.
- `rst` during COMPUTE: the next cycle has `instr` = 0, `out_valid` = 0, IDLE; a following `start` runs a full normal pass.
- `start` pulsed while busy: no effect; `cfg_rows` = 0 behaves as 1, `cfg_rows` = 15 behaves as 9.
